// File: rtl/rtc_pkg.sv
// Shared types, limits and BCD increment helpers for the RTC clock bank.
package rtc_pkg;

    typedef struct packed {
        logic [5:0] hours;
        logic [7:0] minutes;
        logic [7:0] seconds;
    } bcd_time_t;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [5:0] HOUR_MAX = 6'h23;

    // The alarm status bit sits directly above the timer bits.
    function automatic int unsigned alarm_idx(input int unsigned n_timers);
        return n_timers;
    endfunction

    // Returns {carry, next}. Out-of-range inputs are normalised by the >= tests.
    function automatic logic [8:0] bcd_inc_8(input logic [7:0] v, input logic [7:0] max_v);
        logic [8:0] r;
        if (v >= max_v)
            r = 9'h100;
        else if (v[3:0] >= 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v + 8'd1};
        return r;
    endfunction

    function automatic logic [6:0] bcd_inc_hours(input logic [5:0] v);
        logic [6:0] r;
        if (v >= HOUR_MAX)
            r = 7'h40;
        else if (v[3:0] >= 4'd9)
            r = {1'b0, v[5:4] + 2'd1, 4'd0};
        else
            r = {1'b0, v + 6'd1};
        return r;
    endfunction

endpackage

// File: rtl/rtc_timer_chan.sv
// One cycle-timer channel: config registers, free-running counter and
// combinational match event (suppressed by a same-cycle config update).
module rtc_timer_chan
    import rtc_pkg::*;
#(
    parameter int unsigned TIMER_W = 17
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               update_i,
    input  logic               enable_i,
    input  logic               retrig_i,
    input  logic [TIMER_W-1:0] target_i,
    output logic [TIMER_W-1:0] value_o,
    output logic               event_o
);

    logic               en_q, en_d;
    logic               retrig_q, retrig_d;
    logic [TIMER_W-1:0] target_q, target_d;
    logic [TIMER_W-1:0] value_q, value_d;
    logic               hit;

    assign hit     = en_q && (value_q == target_q);
    assign event_o = hit && !update_i;
    assign value_o = value_q;

    always_comb begin
        en_d     = en_q;
        retrig_d = retrig_q;
        target_d = target_q;
        value_d  = value_q;
        if (update_i) begin
            en_d     = enable_i;
            retrig_d = retrig_i;
            target_d = target_i;
            value_d  = '0;
        end else if (en_q) begin
            if (hit) begin
                value_d = '0;
                if (!retrig_q)
                    en_d = 1'b0;
            end else begin
                value_d = value_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q     <= 1'b0;
            retrig_q <= 1'b0;
            target_q <= '0;
            value_q  <= '0;
        end else begin
            en_q     <= en_d;
            retrig_q <= retrig_d;
            target_q <= target_d;
            value_q  <= value_d;
        end
    end

endmodule

// File: rtl/rtc_clock_bank.sv
// RTC core: 1 s prescaler, BCD hh:mm:ss, N cycle timers, one-shot alarm, sticky status.
// Optional: define RTC_ALARM_MASK_EN to store and apply alarm_mask_i.
module rtc_clock_bank
    import rtc_pkg::*;
#(
    parameter int unsigned N_TIMERS = 4,
    parameter int unsigned TIMER_W  = 17,
    parameter int unsigned PRESC_W  = 15,
    parameter int unsigned INIT_W   = 10
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clock_update_i,
    input  logic [21:0]                 clock_i,
    input  logic [INIT_W-1:0]           init_sec_cnt_i,
    output logic [21:0]                 clock_o,
    output logic                        tick_o,
    output logic                        update_day_o,
    input  logic [N_TIMERS-1:0]         timer_update_i,
    input  logic                        timer_enable_i,
    input  logic                        timer_retrig_i,
    input  logic [TIMER_W-1:0]          timer_target_i,
    output logic [N_TIMERS*TIMER_W-1:0] timer_value_o,
    input  logic                        alarm_update_i,
    input  logic                        alarm_enable_i,
    input  logic [2:0]                  alarm_mask_i,
    input  logic [21:0]                 alarm_clock_i,
    output logic [21:0]                 alarm_clock_o,
    input  logic [N_TIMERS:0]           event_clr_i,
    output logic [N_TIMERS:0]           event_status_o,
    output logic                        event_o
);

    localparam int unsigned ALARM_IDX = alarm_idx(N_TIMERS);

    logic [PRESC_W-1:0] presc_q, presc_d;
    bcd_time_t          time_q, time_d;
    logic               tick_q, tick_d;
    logic               day_q, day_d;
    logic               s_sec;
    logic [8:0]         sec_inc, min_inc;
    logic [6:0]         hr_inc;

    assign s_sec   = &presc_q;
    assign sec_inc = bcd_inc_8(time_q.seconds, SEC_MAX);
    assign min_inc = bcd_inc_8(time_q.minutes, MIN_MAX);
    assign hr_inc  = bcd_inc_hours(time_q.hours);

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        time_d  = time_q;
        tick_d  = 1'b0;
        day_d   = 1'b0;
        if (clock_update_i) begin
            presc_d = '0;
            presc_d[PRESC_W-1 -: INIT_W] = init_sec_cnt_i;
            time_d  = bcd_time_t'(clock_i);
        end else if (s_sec) begin
            tick_d         = 1'b1;
            time_d.seconds = sec_inc[7:0];
            if (sec_inc[8]) begin
                time_d.minutes = min_inc[7:0];
                if (min_inc[8]) begin
                    time_d.hours = hr_inc[5:0];
                    day_d        = hr_inc[6];
                end
            end
        end
    end

    // Alarm configuration and evaluation
    bcd_time_t  alarm_q;
    logic       alarm_en_q;
    logic [2:0] alarm_mask;
    logic       alarm_match, alarm_evt;

`ifdef RTC_ALARM_MASK_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            alarm_mask <= '0;
        else if (alarm_update_i)
            alarm_mask <= alarm_mask_i;
    end
`else
    logic unused_alarm_mask;
    assign unused_alarm_mask = ^alarm_mask_i;
    assign alarm_mask = '0;
`endif

    assign alarm_match = (alarm_mask[2] || time_q.hours   == alarm_q.hours)
                      && (alarm_mask[1] || time_q.minutes == alarm_q.minutes)
                      && (alarm_mask[0] || time_q.seconds == alarm_q.seconds);
    // Only a real seconds advance (tick_q) evaluates; a same-cycle update wins.
    assign alarm_evt   = tick_q && alarm_en_q && alarm_match && !alarm_update_i;

    // Timer channels
    logic [N_TIMERS-1:0] timer_evt;

    for (genvar i = 0; i < N_TIMERS; i++) begin : g_chan
        rtc_timer_chan #(.TIMER_W(TIMER_W)) u_chan (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .update_i (timer_update_i[i]),
            .enable_i (timer_enable_i),
            .retrig_i (timer_retrig_i),
            .target_i (timer_target_i),
            .value_o  (timer_value_o[i*TIMER_W +: TIMER_W]),
            .event_o  (timer_evt[i])
        );
    end

    logic [N_TIMERS:0] status_q, status_d, status_set;

    always_comb begin
        status_set                     = '0;
        status_set[N_TIMERS-1:0]       = timer_evt;
        status_set[ALARM_IDX]          = alarm_evt;
        status_d = status_set | (status_q & ~event_clr_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q    <= '0;
            time_q     <= '0;
            tick_q     <= 1'b0;
            day_q      <= 1'b0;
            alarm_q    <= '0;
            alarm_en_q <= 1'b0;
            status_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            time_q   <= time_d;
            tick_q   <= tick_d;
            day_q    <= day_d;
            status_q <= status_d;
            if (alarm_update_i) begin
                alarm_q    <= bcd_time_t'(alarm_clock_i);
                alarm_en_q <= alarm_enable_i;
            end else if (alarm_evt) begin
                alarm_en_q <= 1'b0;
            end
        end
    end

    assign clock_o        = time_q;
    assign tick_o         = tick_q;
    assign update_day_o   = day_q;
    assign alarm_clock_o  = alarm_q;
    assign event_status_o = status_q;
    assign event_o        = |status_q;

endmodule
